aes_host_loader: RTL and testbench

Host-side front end that sits directly upstream of the AES core. It accepts 32-bit word writes of the cipher key and the input text from a simple register-style bus, and presents them as the core's 128-bit `Cipherkey`/`Plaintext` inputs. It launches the core with a one-cycle `Run` pulse, waits for `Ready` under a timeout, and captures the 128-bit `Ciphertext`. The captured result is read back as four 32-bit words.

---
 rtl/aes_host_loader.sv | 119 +++++++++++
 tb/tb_aes_host_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_host_loader.sv
// Loads key/text words from a register bus, launches the AES core, captures its result.
// Latency: start to done = core latency + 2 cycles; writes and start are dropped while busy.
module aes_host_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         start,
    input  logic [1:0]   rd_addr,
    output logic [31:0]  rd_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] Cipherkey,
    output logic [127:0] Plaintext,
    output logic         Run,
    input  logic         Ready,
    input  logic [127:0] Ciphertext
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mask;
    logic [CW-1:0]   cnt;
    logic [127:0]    result;
    logic            accept, reject, capture, expire;
    logic [1:0]      wsel, rsel;

    // Word 0 occupies the top 32 bits, so the slice index is the inverted address.
    assign wsel = ~wr_addr[1:0];
    assign rsel = ~rd_addr;
    assign Run  = (state == LAUNCH);

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (&mask) begin
                        accept    = 1'b1;
                        state_nxt = LAUNCH;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                if (Ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mask      <= '0;
            cnt       <= '0;
            result    <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            Cipherkey <= '0;
            Plaintext <= '0;
        end else begin
            if (state == IDLE && wr_en) begin
                mask[wr_addr] <= 1'b1;
                if (wr_addr[2]) Plaintext[{wsel, 5'b0} +: 32] <= wr_data;
                else            Cipherkey[{wsel, 5'b0} +: 32] <= wr_data;
            end
            // Key stays loaded across operations; each launch needs fresh text.
            if (state == LAUNCH) begin
                mask[7:4] <= 4'b0;
                cnt       <= '0;
            end
            if (state == WAIT && !Ready && !expire) cnt <= cnt + CW'(1);
            if (accept) begin
                busy <= 1'b1;
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (reject) err <= 1'b1;
            if (capture) begin
                result <= Ciphertext;
                done   <= 1'b1;
                busy   <= 1'b0;
            end
            if (expire) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end
            rd_data <= result[{rsel, 5'b0} +: 32];
        end
    end

endmodule

// File: tb/tb_aes_host_loader.sv
// Directed bench: main instance at default TIMEOUT, second instance at TIMEOUT=8 for expiry.
module tb_aes_host_loader;

    logic         Clk;
    logic         Reset, reset_t;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         start, start_t;
    logic [1:0]   rd_addr;
    logic         Ready, ready_t;
    logic [127:0] Ciphertext;

    logic [31:0]  rd_data, rd_data_t;
    logic         busy, done, err, Run;
    logic         busy_t, done_t, err_t, run_t;
    logic [127:0] Cipherkey, Plaintext, key_t, text_t;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'hdeadbeef0badf00dcafef00d12345678;
    localparam logic [127:0] C2 = 128'h11111111222222223333333344444444;

    aes_host_loader u_dut (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err), .Cipherkey(Cipherkey), .Plaintext(Plaintext), .Run(Run),
        .Ready(Ready), .Ciphertext(Ciphertext)
    );

    aes_host_loader #(.TIMEOUT(8)) u_tmo (
        .Clk(Clk), .Reset(reset_t), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_t), .rd_addr(rd_addr), .rd_data(rd_data_t), .busy(busy_t), .done(done_t),
        .err(err_t), .Cipherkey(key_t), .Plaintext(text_t), .Run(run_t),
        .Ready(ready_t), .Ciphertext(Ciphertext)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wvec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rvec_t;

    wvec_t ld  [8];
    wvec_t ld2 [4];
    rvec_t rtab[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int runs;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            ld[i].addr     = 3'(i);
            ld[i].data     = K[(3-i)*32 +: 32];
            ld[i+4].addr   = 3'(i + 4);
            ld[i+4].data   = P[(3-i)*32 +: 32];
            ld2[i].addr    = 3'(i + 4);
            ld2[i].data    = P2[(3-i)*32 +: 32];
        end
        rtab[0] = '{2'd0, 32'h69c4e0d8};
        rtab[1] = '{2'd1, 32'h6a7b0430};
        rtab[2] = '{2'd2, 32'hd8cdb780};
        rtab[3] = '{2'd3, 32'h70b4c55a};

        Reset = 1'b0; reset_t = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_t = 1'b0; rd_addr = '0; Ready = 1'b0; ready_t = 1'b0;
        Ciphertext = '0;
        tick(); tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_key", Cipherkey, 0);
        chk("rst_text", Plaintext, 0);
        chk("rst_run", Run, 0);
        Reset = 1'b1;

        // Full load and a 12-cycle operation
        for (int i = 0; i < 8; i++) wr(ld[i].addr, ld[i].data);
        chk("load_key", Cipherkey, K);
        chk("load_text", Plaintext, P);
        Ciphertext = C;
        start = 1'b1; tick(); start = 1'b0;
        chk("e0_run", Run, 1);
        chk("e0_busy", busy, 1);
        runs = int'(Run);
        for (int i = 1; i <= 12; i++) begin
            Ready = (i == 12);
            tick();
            runs += int'(Run);
            if (i == 1)  chk("e1_run", Run, 0);
            if (i == 11) chk("done_early", done, 0);
        end
        Ready = 1'b0;
        chk("done_e12", done, 1);
        chk("busy_e12", busy, 0);
        chk("run_pulses", 128'(runs), 1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = rtab[i].addr;
            tick();
            chk($sformatf("rd_word%0d", i), rd_data, rtab[i].exp);
        end

        // Incomplete mask rejects start, completing it allows launch
        Reset = 1'b0; tick(); Reset = 1'b1;
        for (int i = 0; i < 7; i++) wr(ld[i].addr, ld[i].data);
        start = 1'b1; tick(); start = 1'b0;
        chk("part_err", err, 1);
        chk("part_run", Run, 0);
        chk("part_busy", busy, 0);
        tick();
        chk("part_run2", Run, 0);
        wr(ld[7].addr, ld[7].data);
        start = 1'b1; tick(); start = 1'b0;
        chk("full_run", Run, 1);
        chk("full_err_clr", err, 0);
        tick();
        Ciphertext = C2; Ready = 1'b1; tick(); Ready = 1'b0;
        chk("op2_done", done, 1);

        // Key retained, only text rewritten
        for (int i = 0; i < 4; i++) wr(ld2[i].addr, ld2[i].data);
        start = 1'b1; tick(); start = 1'b0;
        chk("reuse_run", Run, 1);
        chk("reuse_key", Cipherkey, K);
        chk("reuse_text", Plaintext, P2);
        tick();
        Ready = 1'b1; tick(); Ready = 1'b0;
        chk("reuse_done", done, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("notext_err", err, 1);
        chk("notext_run", Run, 0);
        chk("notext_done_kept", done, 1);

        // Writes and start dropped in WAIT, then reset mid-operation
        for (int i = 4; i < 8; i++) wr(ld[i].addr, ld[i].data);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        wr(3'd4, 32'hffffffff);
        chk("wait_wr_drop", Plaintext, P);
        start = 1'b1; tick(); start = 1'b0;
        chk("wait_start_run", Run, 0);
        chk("wait_busy", busy, 1);
        Reset = 1'b0; tick(); Reset = 1'b1;
        Ready = 1'b1; Ciphertext = C; tick(); Ready = 1'b0; tick();
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_rd", rd_data, 0);
        chk("mid_rst_key", Cipherkey, 0);
        chk("mid_rst_text", Plaintext, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("mid_rst_start_err", err, 1);
        chk("mid_rst_start_run", Run, 0);

        // TIMEOUT=8 instance: Ready left high is captured at the first WAIT edge, then expiry
        reset_t = 1'b1;
        for (int i = 0; i < 8; i++) wr(ld[i].addr, ld[i].data);
        Ciphertext = C;
        start_t = 1'b1; tick(); start_t = 1'b0;
        ready_t = 1'b1;
        tick();
        chk("t_launch_nodone", done_t, 0);
        tick();
        ready_t = 1'b0;
        chk("t_done", done_t, 1);
        rd_addr = 2'd0; tick();
        w = C[127:96];
        chk("t_rd_prior", rd_data_t, w);
        for (int i = 4; i < 8; i++) wr(ld[i].addr, ld[i].data);
        Ciphertext = C2;
        start_t = 1'b1; tick(); start_t = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                chk("t_err_early", err_t, 0);
                chk("t_busy_early", busy_t, 1);
            end
        end
        chk("t_err", err_t, 1);
        chk("t_busy", busy_t, 0);
        chk("t_done_clr", done_t, 0);
        tick();
        chk("t_rd_kept", rd_data_t, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
